iq_power_ramp: RTL



---
 rtl/heai_tx_pkg.sv | 21 ++
 rtl/iq_power_ramp_if.sv | 39 +++
 rtl/iq_gain_scale.sv | 28 ++
 rtl/iq_power_ramp.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/heai_tx_pkg.sv
// Shared types and constants for the GMSK burst transmitter back end.
// Ramp state encoding, default ramp geometry and DAC midscale helpers.
package heai_tx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        STEADY    = 2'd2,
        RAMP_DOWN = 2'd3
    } ramp_state_t;

    localparam int RAMP_SAMPLES_DEFAULT = 16;
    localparam int RAMP_SHIFT           = $clog2(RAMP_SAMPLES_DEFAULT);
    localparam int DAC_WIDTH_DEFAULT    = 6;
    localparam int DAC_MIDSCALE         = 1 << (DAC_WIDTH_DEFAULT - 1);

    function automatic int dac_midscale(input int dac_width);
        return 1 << (dac_width - 1);
    endfunction

endpackage

// File: rtl/iq_power_ramp_if.sv
// Sample-side and DAC-side signals of the power-ramp block.
// The burst controller / bench is the master, iq_power_ramp is the slave.
interface iq_power_ramp_if #(
    parameter int IQ_WIDTH  = 9,
    parameter int DAC_WIDTH = 6
) ();

    logic                        sample_strobe;
    logic                        iq_valid_i;
    logic signed [IQ_WIDTH-1:0]  inphase_i;
    logic signed [IQ_WIDTH-1:0]  quadrature_i;
    logic        [DAC_WIDTH-1:0] dac_inphase_o;
    logic        [DAC_WIDTH-1:0] dac_quadrature_o;
    logic                        txchain_en_o;
    logic                        ramp_busy_o;

    modport master (
        output sample_strobe,
        output iq_valid_i,
        output inphase_i,
        output quadrature_i,
        input  dac_inphase_o,
        input  dac_quadrature_o,
        input  txchain_en_o,
        input  ramp_busy_o
    );

    modport slave (
        input  sample_strobe,
        input  iq_valid_i,
        input  inphase_i,
        input  quadrature_i,
        output dac_inphase_o,
        output dac_quadrature_o,
        output txchain_en_o,
        output ramp_busy_o
    );

endinterface

// File: rtl/iq_gain_scale.sv
// Combinational per-rail scaler: signed sample times ramp gain, divided by the
// ramp length (floor), reduced to DAC_WIDTH bits and converted to offset binary.
module iq_gain_scale
    import heai_tx_pkg::*;
#(
    parameter int IQ_WIDTH   = 9,
    parameter int DAC_WIDTH  = 6,
    parameter int RAMP_SHIFT = 4
) (
    input  logic signed [IQ_WIDTH-1:0]  sample,
    input  logic        [6:0]           gain,
    output logic        [DAC_WIDTH-1:0] code
);

    localparam logic [DAC_WIDTH-1:0] MID = DAC_WIDTH'(dac_midscale(DAC_WIDTH));
    localparam int                   DROP = RAMP_SHIFT + IQ_WIDTH - DAC_WIDTH;

    logic signed [IQ_WIDTH+6:0] product;

    assign product = $signed({{7{sample[IQ_WIDTH-1]}}, sample})
                   * $signed({{IQ_WIDTH{1'b0}}, gain});

    // The scaled sample always fits IQ_WIDTH bits, so shifting out the gain
    // fraction and the discarded LSBs in one step yields its top DAC_WIDTH bits.
    // XOR with midscale flips the MSB: two's complement to offset binary.
    assign code = DAC_WIDTH'(product >>> DROP) ^ MID;

endmodule

// File: rtl/iq_power_ramp.sv
// Power-ramp FSM, shared I/Q gain counter and registered offset-binary DAC outputs.
//   state     | meaning
//   IDLE      | no burst, gain 0, DAC at midscale, TX chain off
//   RAMP_UP   | valid samples arriving, gain climbing toward full scale
//   STEADY    | full gain, held sample tracks each valid strobe
//   RAMP_DOWN | burst ended, sample frozen, gain falls one step per strobe
module iq_power_ramp
    import heai_tx_pkg::*;
#(
    parameter int IQ_WIDTH     = 9,
    parameter int DAC_WIDTH    = 6,
    parameter int RAMP_SAMPLES = RAMP_SAMPLES_DEFAULT
) (
    input  logic           clock,
    input  logic           reset_n,
    iq_power_ramp_if.slave bus
);

    localparam int                   SHIFT     = $clog2(RAMP_SAMPLES);
    localparam int                   GAIN_W    = SHIFT + 1;
    localparam logic [GAIN_W-1:0]    GAIN_FULL = GAIN_W'(RAMP_SAMPLES);
    localparam logic [DAC_WIDTH-1:0] MID       = DAC_WIDTH'(dac_midscale(DAC_WIDTH));

    ramp_state_t                 state_q, state_d;
    logic        [GAIN_W-1:0]    gain_q, gain_d;
    logic                        capture;
    logic signed [IQ_WIDTH-1:0]  held_i_q, held_q_q;
    logic        [DAC_WIDTH-1:0] code_i, code_q;
    logic        [DAC_WIDTH-1:0] dac_i_q, dac_q_q;
    logic                        txchain_en_q, ramp_busy_q;

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        capture = 1'b0;
        if (bus.sample_strobe) begin
            case (state_q)
                IDLE: begin
                    if (bus.iq_valid_i) begin
                        capture = 1'b1;
                        gain_d  = GAIN_W'(1);
                        state_d = RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (bus.iq_valid_i) begin
                        capture = 1'b1;
                        gain_d  = gain_q + GAIN_W'(1);
                        if (gain_d == GAIN_FULL) begin
                            state_d = STEADY;
                        end
                    end else begin
                        // Early burst end: descend from the current gain, no jump.
                        gain_d  = gain_q - GAIN_W'(1);
                        state_d = (gain_d == '0) ? IDLE : RAMP_DOWN;
                    end
                end
                STEADY: begin
                    if (bus.iq_valid_i) begin
                        capture = 1'b1;
                    end else begin
                        gain_d  = gain_q - GAIN_W'(1);
                        state_d = RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    gain_d = gain_q - GAIN_W'(1);
                    if (gain_d == '0) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    gain_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            gain_q   <= '0;
            held_i_q <= '0;
            held_q_q <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            if (capture) begin
                held_i_q <= bus.inphase_i;
                held_q_q <= bus.quadrature_i;
            end
        end
    end

    iq_gain_scale #(
        .IQ_WIDTH   (IQ_WIDTH),
        .DAC_WIDTH  (DAC_WIDTH),
        .RAMP_SHIFT (SHIFT)
    ) u_scale_i (
        .sample (held_i_q),
        .gain   (7'(gain_q)),
        .code   (code_i)
    );

    iq_gain_scale #(
        .IQ_WIDTH   (IQ_WIDTH),
        .DAC_WIDTH  (DAC_WIDTH),
        .RAMP_SHIFT (SHIFT)
    ) u_scale_q (
        .sample (held_q_q),
        .gain   (7'(gain_q)),
        .code   (code_q)
    );

    // Output stage runs every cycle from the post-strobe state, so codes and
    // enables land one edge after the strobe and hold between strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dac_i_q      <= MID;
            dac_q_q      <= MID;
            txchain_en_q <= 1'b0;
            ramp_busy_q  <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                dac_i_q <= MID;
                dac_q_q <= MID;
            end else begin
                dac_i_q <= code_i;
                dac_q_q <= code_q;
            end
            txchain_en_q <= (state_q != IDLE);
            ramp_busy_q  <= (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
        end
    end

    assign bus.dac_inphase_o    = dac_i_q;
    assign bus.dac_quadrature_o = dac_q_q;
    assign bus.txchain_en_o     = txchain_en_q;
    assign bus.ramp_busy_o      = ramp_busy_q;

endmodule
